// File: rtl/alu_pkg.sv
// Shared types for the ALU decode path: control codes, opcode constants,
// the decoded-entry record and an immediate sign-extension helper.
package alu_pkg;

  localparam int ALU_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_ctrl_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_ctrl_e             control;
    logic [ALU_XLEN-1:0]   d1;
    logic [ALU_XLEN-1:0]   d2;
    logic                  illegal;
  } alu_entry_t;

  function automatic logic [ALU_XLEN-1:0] sext12(input logic [11:0] imm);
    return {{(ALU_XLEN-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry in-order buffer between the decoder and the ALU.
// The head entry is always held in r_head so the outputs come straight
// from a register and stay stable under back-pressure.
module alu_skid_buf
  import alu_pkg::*;
#(
  parameter type T = alu_entry_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  buf_state_e r_state;
  buf_state_e w_state_nxt;
  logic       r_in_ready;
  T           r_head;
  T           r_tail;
  logic       w_push;
  logic       w_pop;
  logic       w_ld_head_in;
  logic       w_ld_head_tail;
  logic       w_ld_tail;
  logic       w_clr;

  // in_ready is registered, so FULL blocks pushes even when a pop happens
  assign w_push    = in_valid && r_in_ready;
  assign w_pop     = out_valid && out_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = r_head;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next-state and entry-movement decode; flush overrides any handshake
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_head_in   = 1'b0;
    w_ld_head_tail = 1'b0;
    w_ld_tail      = 1'b0;
    w_clr          = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_clr       = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_state_nxt  = ST_ONE;
            w_ld_head_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            w_ld_head_in = 1'b1;
          end else if (w_push) begin
            w_state_nxt = ST_FULL;
            w_ld_tail   = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_state_nxt    = ST_ONE;
            w_ld_head_tail = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Ready follows the state we are about to enter; held low during reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_in_ready <= 1'b0;
    else        r_in_ready <= (w_state_nxt != ST_FULL);
  end

  // Entry storage; cleared on reset and flush so the outputs read as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (w_clr) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_ld_head_in)   r_head <= in_data;
      if (w_ld_head_tail) r_head <= r_tail;
      if (w_ld_tail)      r_tail <= in_data;
    end
  end

endmodule

// File: rtl/alu_decoder.sv
// RV32I ALU-instruction decoder: combinational decode of the incoming
// instruction into control code and operands, buffered by alu_skid_buf.
module alu_decoder
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_control,
  output logic [XLEN-1:0] out_d1,
  output logic [XLEN-1:0] out_d2,
  output logic            out_illegal
);

  logic [6:0]          w_opcode;
  logic [2:0]          w_funct3;
  logic [6:0]          w_funct7;
  alu_ctrl_e           w_ctrl;
  logic [ALU_XLEN-1:0] w_d2;
  logic                w_legal;
  alu_entry_t          w_entry;
  alu_entry_t          w_head;
  logic                w_unused;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];
  // rs1 index field is resolved upstream by the register file
  assign w_unused = &{1'b0, in_instr[19:15]};

  // Decode opcode/funct fields into control code, operand 2 and legality
  always_comb begin
    w_ctrl  = ALU_ADD;
    w_d2    = '0;
    w_legal = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_ctrl  = alu_ctrl_e'({in_instr[30], w_funct3});
        w_d2    = in_rs2;
        w_legal = (w_funct7 == F7_ZERO) ||
                  ((w_funct7 == F7_ALT) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        w_ctrl = alu_ctrl_e'({(w_funct3 == 3'b101) ? in_instr[30] : 1'b0, w_funct3});
        // Shift-immediates: the upper imm bits select the shift kind, so
        // only the 5-bit shamt is the operand
        if (w_funct3[1:0] == 2'b01) w_d2 = {{(ALU_XLEN-5){1'b0}}, in_instr[24:20]};
        else                        w_d2 = sext12(in_instr[31:20]);
        case (w_funct3)
          3'b001:  w_legal = (w_funct7 == F7_ZERO);
          3'b101:  w_legal = (w_funct7 == F7_ZERO) || (w_funct7 == F7_ALT);
          default: w_legal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        w_ctrl  = ALU_ADD;
        w_d2    = sext12(in_instr[31:20]);
        w_legal = 1'b1;
      end
      OPC_STORE: begin
        w_ctrl  = ALU_ADD;
        w_d2    = sext12({in_instr[31:25], in_instr[11:7]});
        w_legal = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Illegal encodings still flow through, but with zeroed control/operands
  always_comb begin
    w_entry = '0;
    if (w_legal) begin
      w_entry.control = w_ctrl;
      w_entry.d1      = in_rs1;
      w_entry.d2      = w_d2;
      w_entry.illegal = 1'b0;
    end else begin
      w_entry.control = ALU_ADD;
      w_entry.d1      = '0;
      w_entry.d2      = '0;
      w_entry.illegal = 1'b1;
    end
  end

  alu_skid_buf #(
    .T (alu_entry_t)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_head)
  );

  assign out_control = w_head.control;
  assign out_d1      = w_head.d1;
  assign out_d2      = w_head.d2;
  assign out_illegal = w_head.illegal;

endmodule

// File: tb/tb_alu_decoder.sv
// Directed-vector bench for alu_decoder.
module tb_alu_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_control;
  logic [31:0] out_d1;
  logic [31:0] out_d2;
  logic        out_illegal;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_decoder #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_control (out_control),
    .out_d1      (out_d1),
    .out_d2      (out_d2),
    .out_illegal (out_illegal)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic vld, input logic [3:0] ctrl,
                            input logic [31:0] d1, input logic [31:0] d2, input logic ill);
    check_val({tag, ".valid"},   {31'b0, out_valid},   {31'b0, vld});
    check_val({tag, ".control"}, {28'b0, out_control}, {28'b0, ctrl});
    check_val({tag, ".d1"},      out_d1,               d1);
    check_val({tag, ".d2"},      out_d2,               d2);
    check_val({tag, ".illegal"}, {31'b0, out_illegal}, {31'b0, ill});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    in_valid = v;
    in_instr = instr;
    in_rs1   = rs1;
    in_rs2   = rs2;
  endtask

  // Legal vectors: instr, rs1, rs2, expected control, expected d2
  logic [31:0] t_instr [8] = '{32'h00100013, 32'hFFF04013, 32'h00503013, 32'h40000033,
                               32'h40005033, 32'hFF802083, 32'h7FF06013, 32'h01F01013};
  logic [31:0] t_rs1   [8] = '{32'd100, 32'd101, 32'd102, 32'd103,
                               32'd104, 32'd105, 32'd106, 32'd107};
  logic [31:0] t_rs2   [8] = '{32'h22, 32'h23, 32'h24, 32'h25,
                               32'h26, 32'h27, 32'h28, 32'h29};
  logic [3:0]  t_ctrl  [8] = '{4'h0, 4'h4, 4'h3, 4'h8, 4'hD, 4'h0, 4'h6, 4'h1};
  logic [31:0] t_d2    [8] = '{32'h1, 32'hFFFFFFFF, 32'h5, 32'h25,
                               32'h26, 32'hFFFFFFF8, 32'h7FF, 32'd31};
  // Illegal encodings: bad opcode, R-type XOR with alt funct7, SLLI with alt funct7, M-ext MUL
  logic [31:0] t_ill   [4] = '{32'h0000007F, 32'h40004033, 32'h40001013, 32'h02000033};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    #2;
    check_head("reset", 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    check_val("reset.in_ready", {31'b0, in_ready}, 32'h0);
    #10 rst_n = 1'b1;
    step();
    check_val("release.in_ready", {31'b0, in_ready}, 32'h1);
    check_val("release.valid", {31'b0, out_valid}, 32'h0);

    // ADD x3,x1,x2
    out_ready = 1'b1;
    drive(1'b1, 32'h002081B3, 32'd5, 32'd7);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check_head("add", 1'b1, 4'h0, 32'd5, 32'd7, 1'b0);
    step();
    check_val("add.drain", {31'b0, out_valid}, 32'h0);

    // SRAI then SW with negative offset
    drive(1'b1, 32'h4040D093, 32'h80000000, 32'h0);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check_head("srai", 1'b1, 4'hD, 32'h80000000, 32'd4, 1'b0);
    step();
    drive(1'b1, 32'hFE112E23, 32'h100, 32'h55);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check_head("sw", 1'b1, 4'h0, 32'h100, 32'hFFFFFFFC, 1'b0);
    step();

    // Back-to-back stream with out_ready high: one entry per cycle
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, t_instr[i], t_rs1[i], t_rs2[i]);
      step();
      check_head($sformatf("stream%0d", i), 1'b1, t_ctrl[i], t_rs1[i], t_d2[i], 1'b0);
      check_val($sformatf("stream%0d.in_ready", i), {31'b0, in_ready}, 32'h1);
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();
    check_val("stream.drain", {31'b0, out_valid}, 32'h0);

    // Back-pressure: three entries offered, two accepted, then drained in order
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'hA0, 32'h1);
    step();
    check_val("bp.e0.d1", out_d1, 32'hA0);
    check_val("bp.ready1", {31'b0, in_ready}, 32'h1);
    drive(1'b1, 32'h002081B3, 32'hA1, 32'h1);
    step();
    check_val("bp.ready2", {31'b0, in_ready}, 32'h0);
    check_val("bp.hold1.d1", out_d1, 32'hA0);
    drive(1'b1, 32'h002081B3, 32'hA2, 32'h1);
    step();
    check_val("bp.ready3", {31'b0, in_ready}, 32'h0);
    check_val("bp.hold2.d1", out_d1, 32'hA0);
    out_ready = 1'b1;
    step();
    check_val("bp.out1.d1", out_d1, 32'hA1);
    check_val("bp.ready4", {31'b0, in_ready}, 32'h1);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check_val("bp.out2.d1", out_d1, 32'hA2);
    check_val("bp.out2.valid", {31'b0, out_valid}, 32'h1);
    step();
    check_val("bp.drain", {31'b0, out_valid}, 32'h0);

    // Illegal encodings
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, t_ill[i], 32'h3, 32'h4);
      step();
      check_head($sformatf("illegal%0d", i), 1'b1, 4'h0, 32'h0, 32'h0, 1'b1);
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();

    // Flush while FULL with a new entry on offer
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'hB0, 32'h1);
    step();
    drive(1'b1, 32'h002081B3, 32'hB1, 32'h1);
    step();
    check_val("flush.pre.ready", {31'b0, in_ready}, 32'h0);
    drive(1'b1, 32'h002081B3, 32'hDEAD, 32'h1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check_head("flush", 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    check_val("flush.in_ready", {31'b0, in_ready}, 32'h1);
    out_ready = 1'b1;
    step();
    check_val("flush.nothing", {31'b0, out_valid}, 32'h0);

    // Flush in ONE with a simultaneous accepted handshake: entry dropped
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'hC0, 32'h1);
    step();
    drive(1'b1, 32'h002081B3, 32'hC1, 32'h1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check_val("flush1.valid", {31'b0, out_valid}, 32'h0);
    step();
    check_val("flush1.nothing", {31'b0, out_valid}, 32'h0);

    // Asynchronous reset between edges while in ONE
    drive(1'b1, 32'h002081B3, 32'hE0, 32'h1);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check_val("areset.pre.valid", {31'b0, out_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_head("areset", 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    check_val("areset.in_ready", {31'b0, in_ready}, 32'h0);
    #3 rst_n = 1'b1;
    step();
    check_val("areset.release.ready", {31'b0, in_ready}, 32'h1);
    check_val("areset.release.valid", {31'b0, out_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
